// File: rtl/cmp_track.sv
// Registered compare unit with valid/ready handshake, flag output and
// running min/max/equal-count statistics over a clearable window.
module cmp_track #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [6:0]       flags,
    output logic [WIDTH-1:0] y_min,
    output logic [WIDTH-1:0] y_max,
    output logic [CNT_W-1:0] eq_count
);

    logic             out_valid_q, out_valid_d;
    logic [6:0]       flags_q, flags_d;
    logic [WIDTH-1:0] y_min_q, y_min_d;
    logic [WIDTH-1:0] y_max_q, y_max_d;
    logic [CNT_W-1:0] eq_count_q, eq_count_d;
    logic             first_q, first_d;

    logic accept;
    logic clear_eff;
    logic a_lt_b, a_gt_b, a_eq_b;
    logic a_lt_min, a_gt_max;

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    // A clear while the result is held back would disturb the held statistics,
    // so it only takes effect when the output is free to move.
    assign clear_eff = clear && in_ready;

    always_comb begin
        a_eq_b = (a == b);
        if (signed_mode) begin
            a_lt_b   = $signed(a) < $signed(b);
            a_gt_b   = $signed(a) > $signed(b);
            a_lt_min = $signed(a) < $signed(y_min_q);
            a_gt_max = $signed(a) > $signed(y_max_q);
        end else begin
            a_lt_b   = a < b;
            a_gt_b   = a > b;
            a_lt_min = a < y_min_q;
            a_gt_max = a > y_max_q;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        flags_d     = flags_q;
        y_min_d     = y_min_q;
        y_max_d     = y_max_q;
        eq_count_d  = eq_count_q;
        first_d     = first_q;

        if (accept) begin
            out_valid_d = 1'b1;
            flags_d     = {|b, !a_eq_b, a_eq_b, a_gt_b | a_eq_b, a_lt_b | a_eq_b, a_gt_b, a_lt_b};
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (first_q || clear_eff) begin
                y_min_d = a;
                y_max_d = a;
                first_d = 1'b0;
            end else begin
                if (a_lt_min) y_min_d = a;
                if (a_gt_max) y_max_d = a;
            end
            if (clear_eff) begin
                eq_count_d = CNT_W'(a_eq_b);
            end else if (a_eq_b && (eq_count_q != {CNT_W{1'b1}})) begin
                eq_count_d = eq_count_q + CNT_W'(1);
            end
        end else if (clear_eff) begin
            first_d    = 1'b1;
            eq_count_d = '0;
            y_min_d    = '0;
            y_max_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            flags_q     <= '0;
            y_min_q     <= '0;
            y_max_q     <= '0;
            eq_count_q  <= '0;
            first_q     <= 1'b1;
        end else begin
            out_valid_q <= out_valid_d;
            flags_q     <= flags_d;
            y_min_q     <= y_min_d;
            y_max_q     <= y_max_d;
            eq_count_q  <= eq_count_d;
            first_q     <= first_d;
        end
    end

    assign out_valid = out_valid_q;
    assign flags     = flags_q;
    assign y_min     = y_min_q;
    assign y_max     = y_max_q;
    assign eq_count  = eq_count_q;

endmodule
